// File: rtl/pattern_search_ctrl.sv
// Sequencer for a bank of pattern detectors: clear, history fill, bounded search window,
// then a one-cycle DONE with first-hit lane/time, saturating hit count and termination cause.
module pattern_search_ctrl #(
    parameter int LANES       = 16,
    parameter int DEPTH       = 5,
    parameter int TIMEOUT_W   = 16,
    parameter int CNT_W       = 8,
    parameter int STOP_ON_HIT = 0
) (
    input  logic                 clk,
    input  logic                 anrst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [TIMEOUT_W-1:0] timeout,
    input  logic [LANES-1:0]     detected,
    output logic                 det_clr,
    output logic                 det_ena,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] hit_lane,
    output logic [TIMEOUT_W-1:0] hit_time,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic                 timed_out,
    output logic                 aborted
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW = $clog2(LANES + 1);
    localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = CNT_W + PW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FILL   = 3'd2,
        S_SEARCH = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    function automatic logic [PW-1:0] popcount(input logic [LANES-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [LW-1:0] lowest_lane(input logic [LANES-1:0] v);
        logic [LW-1:0] l;
        l = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (v[i]) begin
                l = LW'(i);
            end
        end
        return l;
    endfunction

    state_t               state_r, state_next_s;
    logic [TIMEOUT_W-1:0] timeout_r, idx_r;
    logic [FW-1:0]        fill_r;
    logic                 det_clr_r, det_ena_r, busy_r, done_r;
    logic                 found_r, timed_out_r, aborted_r;
    logic [LW-1:0]        hit_lane_r;
    logic [TIMEOUT_W-1:0] hit_time_r;
    logic [CNT_W-1:0]     hit_cnt_r, cnt_next_s;
    logic [SW-1:0]        cnt_sum_s;
    logic                 start_acc_s, hit_s, win_zero_s, fill_last_s, search_last_s;
    logic                 to_set_s, abort_take_s;

    assign start_acc_s   = (state_r == S_IDLE) && start;
    assign hit_s         = (detected != '0);
    assign win_zero_s    = (timeout_r == '0);
    assign fill_last_s   = (fill_r == FW'((DEPTH > 1) ? DEPTH - 2 : 0));
    assign search_last_s = (idx_r == (timeout_r - TIMEOUT_W'(1)));
    assign cnt_sum_s     = SW'(hit_cnt_r) + SW'(popcount(detected));
    assign cnt_next_s    = (cnt_sum_s > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : cnt_sum_s[CNT_W-1:0];

    // Next-state decode plus the termination-cause strobes for the DONE transition
    always_comb begin
        state_next_s = state_r;
        to_set_s     = 1'b0;
        abort_take_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) state_next_s = S_CLEAR;
                else       state_next_s = S_IDLE;
            end
            S_CLEAR, S_FILL: begin
                if (abort) begin
                    state_next_s = S_DONE;
                    abort_take_s = 1'b1;
                end else if ((state_r == S_CLEAR) && (DEPTH > 1)) begin
                    state_next_s = S_FILL;
                end else if ((state_r == S_CLEAR) || fill_last_s) begin
                    if (win_zero_s) begin
                        state_next_s = S_DONE;
                        to_set_s     = 1'b1;
                    end else begin
                        state_next_s = S_SEARCH;
                    end
                end else begin
                    state_next_s = S_FILL;
                end
            end
            S_SEARCH: begin
                if (abort) begin
                    state_next_s = S_DONE;
                    abort_take_s = 1'b1;
                end else if ((STOP_ON_HIT != 0) && hit_s) begin
                    state_next_s = S_DONE;
                end else if (search_last_s) begin
                    state_next_s = S_DONE;
                    to_set_s     = 1'b1;
                end else begin
                    state_next_s = S_SEARCH;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, phase counters and registered control outputs
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            state_r   <= S_IDLE;
            timeout_r <= '0;
            idx_r     <= '0;
            fill_r    <= '0;
            det_clr_r <= 1'b0;
            det_ena_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            det_clr_r <= (state_next_s == S_CLEAR);
            det_ena_r <= (state_next_s == S_FILL) || (state_next_s == S_SEARCH);
            busy_r    <= (state_next_s != S_IDLE);
            done_r    <= (state_next_s == S_DONE);
            if (start_acc_s) begin
                timeout_r <= timeout;
                idx_r     <= '0;
            end else if (state_r == S_SEARCH) begin
                idx_r <= idx_r + TIMEOUT_W'(1);
            end
            if (state_r == S_CLEAR) fill_r <= '0;
            else if (state_r == S_FILL) fill_r <= fill_r + FW'(1);
        end
    end

    // Search results: cleared on accepted start, held after DONE
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            found_r     <= 1'b0;
            hit_lane_r  <= '0;
            hit_time_r  <= '0;
            hit_cnt_r   <= '0;
            timed_out_r <= 1'b0;
            aborted_r   <= 1'b0;
        end else if (start_acc_s) begin
            found_r     <= 1'b0;
            hit_lane_r  <= '0;
            hit_time_r  <= '0;
            hit_cnt_r   <= '0;
            timed_out_r <= 1'b0;
            aborted_r   <= 1'b0;
        end else begin
            if (state_r == S_SEARCH) begin
                if (hit_s && !found_r) begin
                    found_r    <= 1'b1;
                    hit_lane_r <= lowest_lane(detected);
                    hit_time_r <= idx_r;
                end
                hit_cnt_r <= cnt_next_s;
            end
            if (abort_take_s) aborted_r <= 1'b1;
            if (to_set_s) timed_out_r <= 1'b1;
        end
    end

    assign det_clr   = det_clr_r;
    assign det_ena   = det_ena_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign found     = found_r;
    assign hit_lane  = hit_lane_r;
    assign hit_time  = hit_time_r;
    assign hit_cnt   = hit_cnt_r;
    assign timed_out = timed_out_r;
    assign aborted   = aborted_r;
endmodule

// File: tb/tb_pattern_search_ctrl.sv
// Bench for pattern_search_ctrl: two instances (run full window / stop on hit) share one
// stimulus stream; expectations come from a cycle-indexed reference of the search rules.
module tb_pattern_search_ctrl;
    localparam int LANES = 16;
    localparam int DEPTH = 5;
    localparam int TW    = 16;
    localparam int CW    = 8;
    localparam int MAXC  = 64;

    logic          clk = 1'b0;
    logic          anrst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [TW-1:0] timeout = '0;
    logic [LANES-1:0] detected = '0;
    logic [1:0]    det_clr, det_ena, busy, done, found, timed_out, aborted;
    logic [3:0]    hit_lane [2];
    logic [TW-1:0] hit_time [2];
    logic [CW-1:0] hit_cnt [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pattern_search_ctrl #(
            .LANES(LANES), .DEPTH(DEPTH), .TIMEOUT_W(TW), .CNT_W(CW), .STOP_ON_HIT(g)
        ) dut (
            .clk(clk), .anrst(anrst), .start(start), .abort(abort), .timeout(timeout),
            .detected(detected), .det_clr(det_clr[g]), .det_ena(det_ena[g]), .busy(busy[g]),
            .done(done[g]), .found(found[g]), .hit_lane(hit_lane[g]), .hit_time(hit_time[g]),
            .hit_cnt(hit_cnt[g]), .timed_out(timed_out[g]), .aborted(aborted[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [LANES-1:0] det_tab [MAXC+1];
    int abort_c  = -1;
    int start2_c = -1;
    int  e_done [2];
    bit  e_found [2];
    int  e_lane [2];
    int  e_time [2];
    int  e_cnt [2];
    bit  e_to [2];
    bit  e_ab [2];

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    // Reference: cycle c=1 clear, 2..DEPTH fill, then search cycles; walk them applying the rules
    function automatic void model(input int t);
        for (int d = 0; d < 2; d++) begin
            e_found[d] = 0; e_lane[d] = 0; e_time[d] = 0; e_cnt[d] = 0;
            e_to[d] = 0; e_ab[d] = 0; e_done[d] = -1;
            for (int c = 1; c <= DEPTH + t; c++) begin
                int p;
                p = 0;
                if (c > DEPTH) begin
                    p = $countones(det_tab[c]);
                    if (p > 0 && !e_found[d]) begin
                        e_found[d] = 1;
                        e_time[d]  = c - DEPTH - 1;
                        for (int b = LANES - 1; b >= 0; b--)
                            if (det_tab[c][b]) e_lane[d] = b;
                    end
                    e_cnt[d] = (e_cnt[d] + p > 255) ? 255 : e_cnt[d] + p;
                end
                if (c == abort_c) begin
                    e_ab[d] = 1; e_done[d] = c + 1; break;
                end
                if (d == 1 && p > 0) begin
                    e_done[d] = c + 1; break;
                end
            end
            if (e_done[d] < 0) begin
                e_to[d] = 1; e_done[d] = DEPTH + t + 1;
            end
        end
    endfunction

    task automatic check_results(input int d);
        chk("found", d, 32'(found[d]), 32'(e_found[d]));
        chk("hit_lane", d, 32'(hit_lane[d]), 32'(e_lane[d]));
        chk("hit_time", d, 32'(hit_time[d]), 32'(e_time[d]));
        chk("hit_cnt", d, 32'(hit_cnt[d]), 32'(e_cnt[d]));
        chk("timed_out", d, 32'(timed_out[d]), 32'(e_to[d]));
        chk("aborted", d, 32'(aborted[d]), 32'(e_ab[d]));
    endtask

    task automatic run(input int t);
        int last;
        model(t);
        last = ((e_done[0] > e_done[1]) ? e_done[0] : e_done[1]) + 1;
        @(posedge clk); #1;
        start = 1'b1; timeout = TW'(t); abort = 1'b0; detected = '0;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            start    = (c == start2_c);
            abort    = (c == abort_c);
            detected = det_tab[c];
            for (int d = 0; d < 2; d++) begin
                chk("det_clr", d, 32'(det_clr[d]), 32'(c == 1));
                chk("det_ena", d, 32'(det_ena[d]), 32'(c >= 2 && c < e_done[d]));
                chk("busy", d, 32'(busy[d]), 32'(c <= e_done[d]));
                chk("done", d, 32'(done[d]), 32'(c == e_done[d]));
                if (c == 1) begin
                    chk("clr_found", d, 32'(found[d]), 32'd0);
                    chk("clr_cnt", d, 32'(hit_cnt[d]), 32'd0);
                    chk("clr_flags", d, 32'({timed_out[d], aborted[d]}), 32'd0);
                end
                if (c == e_done[d] || c == last) check_results(d);
            end
        end
        start = 1'b0; abort = 1'b0; detected = '0;
    endtask

    task automatic clear_tab();
        for (int c = 0; c <= MAXC; c++) det_tab[c] = '0;
        abort_c = -1; start2_c = -1;
    endtask

    initial begin
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", d, 32'(busy[d]), 32'd0);
            chk("rst_outs", d, 32'({det_clr[d], det_ena[d], done[d], found[d], hit_cnt[d]}), 32'd0);
        end
        @(posedge clk); #1; anrst = 1'b1;

        // idle window, no hits
        clear_tab(); run(10);
        // two hits; stop-on-hit instance ends at the first one
        clear_tab(); det_tab[DEPTH+1+3] = 16'h0480; det_tab[DEPTH+1+7] = 16'h0001; run(10);
        // hits outside SEARCH are ignored
        clear_tab(); for (int c = 1; c <= DEPTH; c++) det_tab[c] = 16'hFFFF; run(10);
        // count saturation
        clear_tab(); for (int c = 0; c <= MAXC; c++) det_tab[c] = 16'hFFFF; run(20);
        // abort mid-search with an ignored start while busy
        clear_tab(); det_tab[DEPTH+1+1] = 16'h0020; abort_c = DEPTH + 1 + 4; start2_c = 8; run(10);
        // zero-length window, abort in CLEAR, abort in FILL, hit on final window cycle
        clear_tab(); run(0);
        clear_tab(); abort_c = 1; run(10);
        clear_tab(); abort_c = 3; det_tab[3] = 16'h8000; run(4);
        clear_tab(); det_tab[DEPTH+1+5] = 16'hA000; run(6);
        clear_tab(); det_tab[DEPTH+1] = 16'h0300; det_tab[DEPTH+1] = 16'h0300; abort_c = DEPTH + 1; run(8);

        // randomized runs
        for (int r = 0; r < 12; r++) begin
            int t;
            clear_tab();
            t = $urandom_range(0, 14);
            for (int c = 0; c <= MAXC; c++)
                if ($urandom_range(0, 3) == 0) det_tab[c] = LANES'($urandom);
            if ($urandom_range(0, 1) == 1) abort_c = $urandom_range(1, DEPTH + t);
            run(t);
        end

        // asynchronous reset during SEARCH
        clear_tab();
        @(posedge clk); #1; start = 1'b1; timeout = TW'(10);
        for (int c = 1; c <= DEPTH + 1 + 2; c++) begin
            @(posedge clk); #1; start = 1'b0;
            detected = (c > DEPTH) ? 16'h0010 : 16'h0000;
        end
        anrst = 1'b0; #1;
        for (int d = 0; d < 2; d++) begin
            chk("arst_ena", d, 32'(det_ena[d]), 32'd0);
            chk("arst_busy", d, 32'(busy[d]), 32'd0);
            chk("arst_res", d, 32'({found[d], hit_cnt[d], hit_time[d]}), 32'd0);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) chk("arst_done", d, 32'({done[d], busy[d]}), 32'd0);
        end
        detected = '0; anrst = 1'b1;
        run(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
